// File: rtl/aes_decryption_iter_if.sv
// aes_decryption_iter_if
// Request/response bundle for the iterative AES-128 decryption core.
//   start    : request pulse, sampled only while the core is idle
//   CT, KEY  : ciphertext and cipher key, sampled together with start
//   PT       : plaintext, valid from done and held until the next done
//   busy     : high while a block is being processed
//   done     : one-cycle pulse marking a new PT
// Byte order: bit 0 is the MSB of byte 0; bytes fill the state column-major.
// master modport = requester, slave modport = decryption core.
interface aes_decryption_iter_if;
   logic         start;
   logic [0:127] CT;
   logic [0:127] KEY;
   logic [0:127] PT;
   logic         busy;
   logic         done;

   modport master (output start, CT, KEY, input PT, busy, done);
   modport slave  (input start, CT, KEY, output PT, busy, done);
endinterface

// File: rtl/aes_decryption_iter.sv
// aes_decryption_iter
// Iterative AES-128 decryption. After a start, the forward key schedule runs
// for 10 cycles to reach RK10, then the ten inverse rounds run one per cycle
// while each earlier round key is recovered with the inverse key schedule.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : aes_decryption_iter_if.slave (start, CT, KEY in; PT, busy, done out)
// Optional build macro AES_DEC_KEY_CACHE_EN: remembers the last expanded key
// and its RK10, so a repeated key skips the forward schedule (10-cycle latency).
module aes_decryption_iter (
   input  logic                  clk,
   input  logic                  rst,
   aes_decryption_iter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;
   typedef logic [0:127] blk_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse of xtime: used to step rcon backwards (36 -> 1b -> 80 ... -> 01).
   function automatic logic [7:0] div2(input logic [7:0] a);
      return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (zero maps to zero).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   function automatic blk_t inv_mix(input blk_t s);
      blk_t o;
      logic [7:0] a0, a1, a2, a3;
      o = s;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         o[32*c +: 8]    = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
         o[32*c+8 +: 8]  = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
         o[32*c+16 +: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
         o[32*c+24 +: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
      return o;
   endfunction

   fsm_t       fsm_r, fsm_next;
   blk_t       state_r, state_next;
   blk_t       rk_r, rk_next;
   blk_t       pt_r, pt_next;
   logic [7:0] rcon_r, rcon_next;
   logic [3:0] cnt_r, cnt_next;
   logic       busy_r, busy_next;
   logic       done_r, done_next;
`ifdef AES_DEC_KEY_CACHE_EN
   blk_t       key_r, key_next;
   blk_t       key_cache_r, key_cache_next;
   blk_t       rk10_cache_r, rk10_cache_next;
   logic       cache_valid_r, cache_valid_next;
`endif

   // Round-key words; the single SubWord unit is shared between the forward
   // schedule (fed with w3) and the inverse schedule (fed with recovered w3).
   logic [0:31] w0, w1, w2, w3, f0, f1, f2, f3, i0, i1, i2, i3, sub_in, sw;
   wire  [0:31] sub_out;
   wire  [0:127] isb;
   blk_t rk_fwd, rk_inv, dec_t;

   assign w0 = rk_r[0:31];
   assign w1 = rk_r[32:63];
   assign w2 = rk_r[64:95];
   assign w3 = rk_r[96:127];
   assign sub_in = (fsm_r == KEXP) ? w3 : (w3 ^ w2);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fwd_sbox
         assign sub_out[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
      end
      // InvShiftRows folded into the lane wiring: row r moves right by r.
      for (gi = 0; gi < 16; gi++) begin : g_inv_sbox
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
         assign isb[8*gi +: 8] = inv_sbox(state_r[8*SRC +: 8]);
      end
   endgenerate

   assign sw = {sub_out[8:31], sub_out[0:7]};   // RotWord after SubWord

   assign f0 = w0 ^ sw ^ {rcon_r, 24'h0};
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign rk_fwd = {f0, f1, f2, f3};

   assign i3 = w3 ^ w2;
   assign i2 = w2 ^ w1;
   assign i1 = w1 ^ w0;
   assign i0 = w0 ^ sw ^ {rcon_r, 24'h0};
   assign rk_inv = {i0, i1, i2, i3};

   assign dec_t = isb ^ rk_inv;

   always_comb begin
      fsm_next   = fsm_r;
      state_next = state_r;
      rk_next    = rk_r;
      pt_next    = pt_r;
      rcon_next  = rcon_r;
      cnt_next   = cnt_r;
      busy_next  = busy_r;
      done_next  = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      key_next         = key_r;
      key_cache_next   = key_cache_r;
      rk10_cache_next  = rk10_cache_r;
      cache_valid_next = cache_valid_r;
`endif
      case (fsm_r)
         IDLE: begin
            if (bus.start) begin
               busy_next = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
               key_next = bus.KEY;
               if (cache_valid_r && (bus.KEY == key_cache_r)) begin
                  rk_next    = rk10_cache_r;
                  state_next = bus.CT ^ rk10_cache_r;
                  rcon_next  = 8'h36;
                  cnt_next   = 4'd9;
                  fsm_next   = DEC;
               end else begin
                  state_next = bus.CT;
                  rk_next    = bus.KEY;
                  rcon_next  = 8'h01;
                  cnt_next   = 4'd0;
                  fsm_next   = KEXP;
               end
`else
               state_next = bus.CT;
               rk_next    = bus.KEY;
               rcon_next  = 8'h01;
               cnt_next   = 4'd0;
               fsm_next   = KEXP;
`endif
            end
         end
         KEXP: begin
            rk_next   = rk_fwd;
            rcon_next = xtime(rcon_r);
            cnt_next  = cnt_r + 4'd1;
            if (cnt_r == 4'd9) begin
               // rcon stays at 36: the first inverse step needs rcon_10.
               state_next = state_r ^ rk_fwd;
               rcon_next  = rcon_r;
               cnt_next   = 4'd9;
               fsm_next   = DEC;
`ifdef AES_DEC_KEY_CACHE_EN
               key_cache_next   = key_r;
               rk10_cache_next  = rk_fwd;
               cache_valid_next = 1'b1;
`endif
            end
         end
         DEC: begin
            rk_next   = rk_inv;
            rcon_next = div2(rcon_r);
            cnt_next  = cnt_r - 4'd1;
            if (cnt_r == 4'd0) begin
               // rk_inv is RK0 (the cipher key) here.
               pt_next   = dec_t;
               done_next = 1'b1;
               busy_next = 1'b0;
               fsm_next  = IDLE;
            end else begin
               state_next = inv_mix(dec_t);
            end
         end
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_r   <= IDLE;
         state_r <= '0;
         rk_r    <= '0;
         pt_r    <= '0;
         rcon_r  <= '0;
         cnt_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
         key_r         <= '0;
         key_cache_r   <= '0;
         rk10_cache_r  <= '0;
         cache_valid_r <= 1'b0;
`endif
      end else begin
         fsm_r   <= fsm_next;
         state_r <= state_next;
         rk_r    <= rk_next;
         pt_r    <= pt_next;
         rcon_r  <= rcon_next;
         cnt_r   <= cnt_next;
         busy_r  <= busy_next;
         done_r  <= done_next;
`ifdef AES_DEC_KEY_CACHE_EN
         key_r         <= key_next;
         key_cache_r   <= key_cache_next;
         rk10_cache_r  <= rk10_cache_next;
         cache_valid_r <= cache_valid_next;
`endif
      end
   end

   assign bus.PT   = pt_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
endmodule
